pix_buff_reader: RTL
====================

Name: pix_buff_reader

Overview:
- Read-side drain controller for the PIX_BUFF pixel FIFO.
- Issues FIFO read enables against a credit budget and absorbs the FIFO's fixed read latency in a small local queue.
- Presents pixels as a valid/ready stream with raster position (x/y) and frame markers.
- Sits between the PIX_BUFF read port and downstream pixel consumers (display or recognition pipeline).

Parameters:
- DATA_WIDTH, 16: pixel word width; equals PIX_BUFF read data width.
- OUTPUT_REG, 0: matches the FIFO output-register setting; read latency LAT = 1 + OUTPUT_REG.
- H_ACTIVE, 640: pixels per line.
- V_ACTIVE, 480: lines per frame.
- CNT_W, 12: x/y counter width; must satisfy 2^CNT_W >= max(H_ACTIVE, V_ACTIVE).

Ports:
- rd_clk  in  1  single clock for the block (same clock as the FIFO read side).
- rd_rst  in  1  reset, asynchronous assert, active-high.
- fifo_rd_en  out  1  read enable to the FIFO.
- fifo_rd_oce  out  1  FIFO output-register enable; tied 1 when OUTPUT_REG=1, else 0.
- fifo_rd_data  in  DATA_WIDTH  FIFO read data.
- fifo_rd_empty  in  1  FIFO empty flag (registered inside the FIFO).
- cnt_clr  in  1  synchronous clear of x/y counters; queued data is untouched.
- m_valid  out  1  stream data valid.
- m_ready  in  1  downstream ready.
- m_data  out  DATA_WIDTH  pixel data.
- m_sof  out  1  first pixel of frame (x=0, y=0); qualified by m_valid.
- m_eol  out  1  last pixel of line (x=H_ACTIVE-1).
- m_eof  out  1  last pixel of frame (m_eol and y=V_ACTIVE-1).
- x_cnt  out  CNT_W  column of the current m_data.
- y_cnt  out  CNT_W  row of the current m_data.
- frame_done  out  1  one-cycle pulse the cycle after the eof beat is accepted.

Behaviour:
- Reset (rd_rst high, async): all outputs 0, queue empty, in-flight tracker cleared, counters 0. Deassertion takes effect on the next rd_clk edge.
- Reset mid-frame: in-flight reads are discarded. The system resets the FIFO read side on the same rd_rst, so no stale data returns.
- Queue: local sync FIFO, depth QD = LAT+2 entries.
- In-flight tracker: LAT-stage shift register, bit set when fifo_rd_en=1.
- fifo_rd_en: combinational, = !fifo_rd_empty && (q_count + inflight_count < QD). Never asserted while empty, so FIFO underflow is impossible.
- Capture: when the tracker's last stage is 1, fifo_rd_data is written into the queue at that edge.
- Latency: rd_en in cycle N → data valid at FIFO output in cycle N+LAT → m_valid high in cycle N+LAT+1.
- Credit rule guarantees the queue never overflows. An overflow attempt asserts a simulation-only assertion error.
- Throughput: sustains 1 beat/cycle while m_ready=1 and the FIFO is non-empty.
- Handshake:
  - Beat accepted when m_valid && m_ready.
  - m_data, m_sof, m_eol, m_eof, x_cnt and y_cnt hold stable while m_valid && !m_ready.
  - m_valid never drops without acceptance.
- Simultaneous queue write and read in one cycle: both occur and q_count is unchanged. An empty queue does not bypass to the output; data always passes through the queue.
- Counters advance only on accepted beats:
  - x increments; at H_ACTIVE-1, x wraps to 0 and y increments.
  - At x=H_ACTIVE-1 and y=V_ACTIVE-1, both wrap to 0.
- cnt_clr forces x=y=0 next cycle and has priority over an accepted beat in the same cycle.
- frame_done: registered; = accepted beat with m_eof. Cleared by reset.
- No state machine beyond the counters. Control is credit plus queue.

Decomposition:
- pix_buff_pkg holds:
  - the LAT and QD derivation functions;
  - clog2 helper;
  - H_ACTIVE/V_ACTIVE defaults shared with the PIX_BUFF writer side.
- Sub-module pix_buff_skid_q: parameterised sync FIFO (depth QD, width DATA_WIDTH) with count output; reset async active-high.
- Counters, credit logic and tracker stay in the top.

Test Plan:
- OUTPUT_REG=0, FIFO preloaded with 4 words 0x0001..0x0004, m_ready=1 → fifo_rd_en first cycle after reset release; m_valid 2 cycles later; 4 consecutive beats in order; m_sof on 0x0001; fifo_rd_en never high while empty.
- OUTPUT_REG=1, continuous FIFO supply, m_ready=1 → steady 1 beat/cycle after a 3-cycle fill; fifo_rd_oce=1.
- m_ready toggled by a random 30% pattern for 1000 beats → no loss or duplication; outputs stable during stalls; q_count+inflight never exceeds QD.
- H_ACTIVE=4, V_ACTIVE=2, 8 beats → m_eol on x=3 at y=0,1; m_eof on beat 8; frame_done pulses once the next cycle; beat 9 has m_sof=1, x=0, y=0.
- cnt_clr asserted at x=2, y=1 coinciding with an accepted beat → next beat reports x=0, y=0, m_sof=1.
- rd_rst pulsed with 2 reads in flight and 3 words queued → m_valid=0 immediately; counters 0; after release and a new FIFO write, the first beat is the new word.

Source files
------------

// File: rtl/pix_buff_pkg.sv
// pix_buff_pkg: shared PIX_BUFF raster defaults plus latency, queue-depth and clog2 helpers
package pix_buff_pkg;
  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  function automatic int clog2(input int v);
    int r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
  function automatic int calc_lat(input int output_reg);
    return output_reg != 0 ? 2 : 1;
  endfunction
  function automatic int calc_qd(input int lat);
    return lat + 2;
  endfunction
endpackage

// File: rtl/pix_buff_reader_if.sv
// pix_buff_reader_if: pixel stream (valid/ready, data, sof/eol/eof, x/y); master drives, slave sinks
interface pix_buff_reader_if #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_W = 12
);
  logic m_valid, m_ready, m_sof, m_eol, m_eof;
  logic [DATA_WIDTH-1:0] m_data;
  logic [CNT_W-1:0] x_cnt, y_cnt;
  modport master (output m_valid, m_data, m_sof, m_eol, m_eof, x_cnt, y_cnt, input m_ready);
  modport slave (input m_valid, m_data, m_sof, m_eol, m_eof, x_cnt, y_cnt, output m_ready);
endinterface

// File: rtl/pix_buff_skid_q.sv
// pix_buff_skid_q: DEPTH x WIDTH sync FIFO (clk, rst, i_wr/i_wdata, i_rd, o_rdata head, o_count)
module pix_buff_skid_q
  import pix_buff_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_wr,
  input  logic [WIDTH-1:0]            i_wdata,
  input  logic                        i_rd,
  output logic [WIDTH-1:0]            o_rdata,
  output logic [clog2(DEPTH+1)-1:0]   o_count
);
  localparam int AW = clog2(DEPTH);
  localparam int CW = clog2(DEPTH + 1);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_cnt;
  logic w_wr, w_rd;
  assign w_rd = i_rd && r_cnt != '0;
  assign w_wr = i_wr && (r_cnt != CW'(DEPTH) || w_rd);
  assign o_rdata = r_mem[r_rp];
  assign o_count = r_cnt;
  always_ff @(posedge clk) if (w_wr) r_mem[r_wp] <= i_wdata;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr) r_wp <= r_wp == AW'(DEPTH - 1) ? '0 : r_wp + 1'b1;
      if (w_rd) r_rp <= r_rp == AW'(DEPTH - 1) ? '0 : r_rp + 1'b1;
      r_cnt <= r_cnt + CW'(w_wr) - CW'(w_rd);
    end
  always @(posedge clk) if (!rst) assert (!(i_wr && !w_wr));
endmodule

// File: rtl/pix_buff_reader.sv
// pix_buff_reader: credit-based PIX_BUFF drain (fifo_rd_* side) to a raster-tagged pixel stream m
module pix_buff_reader
  import pix_buff_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int OUTPUT_REG = 0,
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int CNT_W = 12
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  output logic                  fifo_rd_en,
  output logic                  fifo_rd_oce,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_rd_empty,
  input  logic                  cnt_clr,
  pix_buff_reader_if.master     m,
  output logic                  frame_done
);
  localparam int LAT = calc_lat(OUTPUT_REG);
  localparam int QD = calc_qd(LAT);
  localparam int CW = clog2(QD + 1);
  logic [LAT-1:0] r_trk;
  logic [CNT_W-1:0] r_x, r_y;
  logic [CW-1:0] w_q_cnt, w_infl;
  logic [DATA_WIDTH-1:0] w_head;
  logic w_acc, w_eol, w_eof;
  always_comb begin
    w_infl = '0;
    for (int i = 0; i < LAT; i++) w_infl = w_infl + CW'(r_trk[i]);
  end
  // queued plus in-flight words never exceed QD, so every returning word has a slot
  assign fifo_rd_en = !rd_rst && !fifo_rd_empty && ({1'b0, w_q_cnt} + {1'b0, w_infl} < (CW+1)'(QD));
  assign fifo_rd_oce = OUTPUT_REG != 0;
  assign w_acc = m.m_valid && m.m_ready;
  assign w_eol = r_x == CNT_W'(H_ACTIVE - 1);
  assign w_eof = w_eol && r_y == CNT_W'(V_ACTIVE - 1);
  assign m.m_valid = w_q_cnt != '0;
  assign m.m_data = m.m_valid ? w_head : '0;
  assign m.m_sof = m.m_valid && r_x == '0 && r_y == '0;
  assign m.m_eol = m.m_valid && w_eol;
  assign m.m_eof = m.m_valid && w_eof;
  assign m.x_cnt = r_x;
  assign m.y_cnt = r_y;
  pix_buff_skid_q #(.DEPTH(QD), .WIDTH(DATA_WIDTH)) u_q (
    .clk(rd_clk), .rst(rd_rst), .i_wr(r_trk[LAT-1]), .i_wdata(fifo_rd_data),
    .i_rd(w_acc), .o_rdata(w_head), .o_count(w_q_cnt)
  );
  always_ff @(posedge rd_clk or posedge rd_rst)
    if (rd_rst) begin
      r_trk <= '0;
      r_x <= '0;
      r_y <= '0;
      frame_done <= 1'b0;
    end else begin
      r_trk <= LAT'({r_trk, fifo_rd_en});
      frame_done <= w_acc && w_eof;
      r_x <= cnt_clr ? '0 : w_acc ? (w_eol ? '0 : r_x + 1'b1) : r_x;
      r_y <= cnt_clr ? '0 : (w_acc && w_eol) ? (w_eof ? '0 : r_y + 1'b1) : r_y;
    end
endmodule
